// File: rtl/cim_argmin_scanner_pkg.sv
// Shared types and helpers for the CiM argmin scanner and its neighbours.
package cim_argmin_scanner_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } scan_state_t;

  // Index/counter width for a group of n results; one spare bit so the
  // counter can express n itself without wrapping.
  function automatic int count_w(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/cim_argmin_scanner_cmp_unit.sv
// Single magnitude comparator: lt = (a < b), unsigned or two's-complement.
module cim_argmin_scanner_cmp_unit #(
  parameter int DATA_WIDTH = 32,
  parameter bit SIGNED     = 1'b0
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  lt
);

  logic signed [DATA_WIDTH-1:0] a_s;
  logic signed [DATA_WIDTH-1:0] b_s;

  assign a_s = a;
  assign b_s = b;

  generate
    if (SIGNED) begin : g_signed
      assign lt = (a_s < b_s);
    end else begin : g_unsigned
      assign lt = (a < b);
    end
  endgenerate

endmodule

// File: rtl/cim_argmin_scanner.sv
// Sequential argmin over a snapshot of N_GROUP cell results: one element is
// compared per cycle against the running best, so a single comparator serves
// the whole group. The result is presented with a one-cycle done pulse.
module cim_argmin_scanner
  import cim_argmin_scanner_pkg::*;
#(
  parameter int  N_GROUP     = 12,
  parameter int  DATA_WIDTH  = 32,
  parameter bit  SIGNED      = 1'b0,
  localparam int COUNT_WIDTH = count_w(N_GROUP)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic [N_GROUP-1:0][DATA_WIDTH-1:0]  data_i,
  output logic                                busy,
  output logic                                done,
  output logic [DATA_WIDTH-1:0]               min_o,
  output logic [COUNT_WIDTH-1:0]              idx_o
);

  scan_state_t                       state;
  logic [COUNT_WIDTH-1:0]            cnt;
  logic [N_GROUP-1:0][DATA_WIDTH-1:0] snap;
  logic [DATA_WIDTH-1:0]             best;
  logic [COUNT_WIDTH-1:0]            best_idx;

  logic [DATA_WIDTH-1:0]             cur;
  logic                              lt;
  logic [DATA_WIDTH-1:0]             nxt_best;
  logic [COUNT_WIDTH-1:0]            nxt_idx;
  logic                              last;
  logic                              take;

  // Select the snapshot element addressed by the scan counter.
  always_comb begin
    cur = snap[0];
    for (int g = 1; g < N_GROUP; g++) begin
      if (cnt == COUNT_WIDTH'(g)) cur = snap[g];
    end
  end

  cim_argmin_scanner_cmp_unit #(
    .DATA_WIDTH (DATA_WIDTH),
    .SIGNED     (SIGNED)
  ) u_cmp (
    .a  (cur),
    .b  (best),
    .lt (lt)
  );

  // Strict less-than keeps the earlier index on ties.
  always_comb begin
    nxt_best = lt ? cur : best;
    nxt_idx  = lt ? cnt : best_idx;
    last     = (cnt == COUNT_WIDTH'(N_GROUP - 1));
    take     = start && (state != SCAN);
  end

  // Scan FSM with capture, running-best update and registered result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      min_o    <= '0;
      idx_o    <= '0;
      cnt      <= '0;
      snap     <= '0;
      best     <= '0;
      best_idx <= '0;
    end else begin
      done <= 1'b0;
      if (take) begin
        // Capture stage: element 0 seeds the running best.
        snap     <= data_i;
        best     <= data_i[0];
        best_idx <= '0;
        cnt      <= COUNT_WIDTH'(1);
        if (N_GROUP == 1) begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
          min_o <= data_i[0];
          idx_o <= '0;
        end else begin
          state <= SCAN;
          busy  <= 1'b1;
        end
      end else begin
        case (state)
          SCAN: begin
            // Compare stage: fold element cnt into the running best.
            best     <= nxt_best;
            best_idx <= nxt_idx;
            cnt      <= cnt + COUNT_WIDTH'(1);
            if (last) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              min_o <= nxt_best;
              idx_o <= nxt_idx;
            end
          end
          DONE:    state <= IDLE;
          IDLE:    state <= IDLE;
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cim_argmin_scanner.sv
// Bench for cim_argmin_scanner: unsigned and signed 12-element instances
// share stimulus; a 1-element instance covers the degenerate group.
module tb_cim_argmin_scanner;

  localparam int N = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic                 start12 = 1'b0;
  logic [N-1:0][31:0]   data12  = '0;
  logic                 busy_u, done_u, busy_s, done_s;
  logic [31:0]          min_u, min_s;
  logic [4:0]           idx_u, idx_s;

  logic                 start1 = 1'b0;
  logic [0:0][31:0]     data1  = '0;
  logic                 busy1, done1;
  logic [31:0]          min1;
  logic [0:0]           idx1;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  cim_argmin_scanner #(.N_GROUP(N), .DATA_WIDTH(32), .SIGNED(1'b0)) u_uns (
    .clk(clk), .rst(rst), .start(start12), .data_i(data12),
    .busy(busy_u), .done(done_u), .min_o(min_u), .idx_o(idx_u));

  cim_argmin_scanner #(.N_GROUP(N), .DATA_WIDTH(32), .SIGNED(1'b1)) u_sgn (
    .clk(clk), .rst(rst), .start(start12), .data_i(data12),
    .busy(busy_s), .done(done_s), .min_o(min_s), .idx_o(idx_s));

  cim_argmin_scanner #(.N_GROUP(1), .DATA_WIDTH(32), .SIGNED(1'b0)) u_one (
    .clk(clk), .rst(rst), .start(start1), .data_i(data1),
    .busy(busy1), .done(done1), .min_o(min1), .idx_o(idx1));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: first position holding the smallest value under the chosen ordering.
  task automatic ref_argmin(input logic [31:0] d[N], input bit sgn,
                            output logic [31:0] mn, output logic [31:0] ix);
    longint v, bv;
    bv = 64'sh7fff_ffff_ffff_ffff;
    mn = 32'h0;
    ix = 32'h0;
    for (int g = 0; g < N; g++) begin
      v = sgn ? longint'($signed(d[g])) : longint'({32'h0, d[g]});
      if (v < bv) begin
        bv = v;
        mn = d[g];
        ix = g;
      end
    end
  endtask

  // One scan on the 12-element pair; data_i is scrambled after capture.
  task automatic scan12(input string tag, input logic [31:0] d[N]);
    logic [31:0] emu, eiu, ems, eis;
    int n, busy_n;
    bit found;
    ref_argmin(d, 1'b0, emu, eiu);
    ref_argmin(d, 1'b1, ems, eis);
    for (int g = 0; g < N; g++) data12[g] = d[g];
    start12 = 1'b1;
    step();
    start12 = 1'b0;
    for (int g = 0; g < N; g++) data12[g] = $urandom;
    n = 0; busy_n = 0; found = 1'b0;
    while (!found && n < 40) begin
      if (busy_u) busy_n++;
      step();
      n++;
      if (done_u) found = 1'b1;
    end
    check({tag, " done_seen"}, 32'(found), 32'd1);
    check({tag, " latency"}, n, N - 1);
    check({tag, " busy_cycles"}, busy_n, N - 1);
    check({tag, " done_sgn"}, 32'(done_s), 32'd1);
    check({tag, " min_uns"}, min_u, emu);
    check({tag, " idx_uns"}, 32'(idx_u), eiu);
    check({tag, " min_sgn"}, min_s, ems);
    check({tag, " idx_sgn"}, 32'(idx_s), eis);
    step();
    check({tag, " done_pulse"}, 32'(done_u), 32'd0);
    check({tag, " min_hold"}, min_u, emu);
  endtask

  logic [31:0] d[N];
  logic [31:0] hist[48][N];
  logic [31:0] tmp[N];
  logic [31:0] em, ei;

  initial begin
    // Reset state.
    #1;
    check("rst busy", 32'(busy_u), 32'd0);
    check("rst done", 32'(done_u), 32'd0);
    check("rst min", min_u, 32'd0);
    check("rst idx", 32'(idx_u), 32'd0);
    check("rst min1", min1, 32'd0);
    step();
    step();
    rst = 1'b0;
    step();

    // Descending values: minimum at the last element.
    for (int g = 0; g < N; g++) d[g] = 32'(100 - g);
    scan12("desc", d);
    check("desc min_const", min_u, 32'h59);
    check("desc idx_const", 32'(idx_u), 32'd11);
    for (int c = 0; c < 3; c++) begin
      step();
      check("desc no_extra_done", 32'(done_u), 32'd0);
    end

    // Tie between positions 3 and 8.
    for (int g = 0; g < N; g++) d[g] = 32'h7;
    d[3] = 32'h2;
    d[8] = 32'h2;
    scan12("tie", d);
    check("tie idx_const", 32'(idx_u), 32'd3);

    // Negative value under signed ordering, largest under unsigned.
    for (int g = 0; g < N; g++) d[g] = 32'h1;
    d[5] = 32'hFFFF_FFFF;
    scan12("sign", d);
    check("sign min_s_const", min_s, 32'hFFFF_FFFF);
    check("sign idx_s_const", 32'(idx_s), 32'd5);
    check("sign min_u_const", min_u, 32'h1);
    check("sign idx_u_const", 32'(idx_u), 32'd0);

    // Random scans: narrow range forces ties, full range mixes signs.
    for (int t = 0; t < 8; t++) begin
      for (int g = 0; g < N; g++)
        d[g] = (t % 2 == 0) ? 32'($urandom_range(0, 7)) : $urandom;
      scan12("rand", d);
    end

    // Start held high with data changing every cycle.
    step();
    for (int j = 0; j < 48; j++) begin
      for (int g = 0; g < N; g++) begin
        hist[j][g] = $urandom;
        data12[g]  = hist[j][g];
      end
      start12 = 1'b1;
      step();
      if (j % N == N - 1) begin
        for (int g = 0; g < N; g++) tmp[g] = hist[j - (N - 1)][g];
        ref_argmin(tmp, 1'b0, em, ei);
        check("stream done", 32'(done_u), 32'd1);
        check("stream min", min_u, em);
        check("stream idx", 32'(idx_u), ei);
        ref_argmin(tmp, 1'b1, em, ei);
        check("stream min_sgn", min_s, em);
        check("stream idx_sgn", 32'(idx_s), ei);
      end else begin
        check("stream no_done", 32'(done_u), 32'd0);
      end
    end
    start12 = 1'b0;
    step();
    step();

    // Reset five cycles into a scan aborts it immediately.
    for (int g = 0; g < N; g++) d[g] = $urandom;
    for (int g = 0; g < N; g++) data12[g] = d[g];
    start12 = 1'b1;
    step();
    start12 = 1'b0;
    for (int c = 0; c < 5; c++) step();
    check("abort busy_before", 32'(busy_u), 32'd1);
    rst = 1'b1;
    #1;
    check("abort busy", 32'(busy_u), 32'd0);
    check("abort done", 32'(done_u), 32'd0);
    check("abort min", min_u, 32'd0);
    check("abort idx", 32'(idx_u), 32'd0);
    step();
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step();
      check("abort no_done", 32'(done_u | done_s), 32'd0);
    end
    for (int g = 0; g < N; g++) d[g] = $urandom;
    scan12("after_abort", d);

    // Single-element group: done the cycle after start, never busy.
    data1[0] = 32'h1234;
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    data1[0] = 32'hFFFF;
    check("one done", 32'(done1), 32'd1);
    check("one busy", 32'(busy1), 32'd0);
    check("one min", min1, 32'h1234);
    check("one idx", 32'(idx1), 32'd0);
    step();
    check("one pulse", 32'(done1), 32'd0);
    check("one hold", min1, 32'h1234);
    for (int j = 0; j < 4; j++) begin
      em = $urandom;
      data1[0] = em;
      start1 = 1'b1;
      step();
      check("one b2b done", 32'(done1), 32'd1);
      check("one b2b busy", 32'(busy1), 32'd0);
      check("one b2b min", min1, em);
    end
    start1 = 1'b0;
    step();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
